// File: rtl/chimera_clu_clk_ctrl.sv
// Per-cluster clock-gating sequencer: isolate, drain outstanding narrow AXI traffic,
// gate once idle, and run a timed wake on release. One independent FSM per cluster.
module chimera_clu_clk_ctrl #(
  parameter int unsigned NumClusters    = 5,
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned WakeCycles     = 4,
  parameter int unsigned DrainTimeout   = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] gate_req_i,
  input  logic [NumClusters-1:0] clu_busy_i,
  input  logic [NumClusters-1:0] txn_start_i,
  input  logic [NumClusters-1:0] txn_end_i,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] gated_o,
  output logic [NumClusters-1:0] timeout_o,
  output logic [NumClusters-1:0] cnt_err_o
);

  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned DrainW = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
  localparam int unsigned WakeW  = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;

  localparam logic [CntW-1:0]   CntMax    = CntW'(MaxOutstanding);
  localparam logic [DrainW-1:0] DrainLast = DrainW'((DrainTimeout > 0) ? DrainTimeout - 1 : 0);
  localparam logic [WakeW-1:0]  WakeLast  = WakeW'((WakeCycles > 0) ? WakeCycles - 1 : 0);

  localparam logic [2:0] ACTIVE  = 3'd0;
  localparam logic [2:0] ISOLATE = 3'd1;
  localparam logic [2:0] DRAIN   = 3'd2;
  localparam logic [2:0] GATED   = 3'd3;
  localparam logic [2:0] WAKE    = 3'd4;

  if (WakeCycles < 1) begin : g_bad_wake
    $fatal(1, "chimera_clu_clk_ctrl: WakeCycles must be >= 1");
  end

  for (genvar i = 0; i < NumClusters; i++) begin : g_clu
    logic [2:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [DrainW-1:0] drain_q;
    logic [WakeW-1:0]  wake_q;
    logic              rearm_q, timeout_q, err_q;
    logic              idle, drain_expire, timeout_hit;

    // Idle uses the registered count, so an end pulse in this cycle only counts next cycle.
    assign idle         = (cnt_q == '0) && !clu_busy_i[i];
    assign drain_expire = (DrainTimeout != 0) && (drain_q == DrainLast);
    assign timeout_hit  = (state_q == DRAIN) && gate_req_i[i] && !idle && drain_expire;

    always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
        ACTIVE:  if (gate_req_i[i] && rearm_q) state_d = ISOLATE;
        ISOLATE: state_d = DRAIN;
        DRAIN: begin
          if (!gate_req_i[i])    state_d = ACTIVE;
          else if (idle)         state_d = GATED;
          else if (drain_expire) state_d = ACTIVE;
        end
        GATED:   if (!gate_req_i[i]) state_d = WAKE;
        WAKE:    if (wake_q == WakeLast) state_d = ACTIVE;
        default: state_d = ACTIVE;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q   <= ACTIVE;
        drain_q   <= '0;
        wake_q    <= '0;
        rearm_q   <= 1'b1;
        timeout_q <= 1'b0;
      end else begin
        state_q <= state_d;
        drain_q <= (state_q == DRAIN) ? drain_q + DrainW'(1) : '0;
        wake_q  <= (state_q == WAKE)  ? wake_q + WakeW'(1)   : '0;
        if (!gate_req_i[i]) begin
          rearm_q   <= 1'b1;
          timeout_q <= 1'b0;
        end else if (timeout_hit) begin
          rearm_q   <= 1'b0;
          timeout_q <= 1'b1;
        end
      end
    end

    // Outstanding counter runs in every state; simultaneous start and end cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (txn_start_i[i] && !txn_end_i[i]) begin
        if (cnt_q == CntMax) err_q <= 1'b1;
        else                 cnt_q <= cnt_q + CntW'(1);
      end else if (txn_end_i[i] && !txn_start_i[i]) begin
        if (cnt_q == '0) err_q <= 1'b1;
        else             cnt_q <= cnt_q - CntW'(1);
      end
    end

    assign clk_en_o[i]  = (state_q != GATED);
    assign isolate_o[i] = (state_q != ACTIVE);
    assign gated_o[i]   = (state_q == GATED);
    assign timeout_o[i] = timeout_q;
    assign cnt_err_o[i] = err_q;
  end

endmodule

// File: tb/tb_chimera_clu_clk_ctrl.sv
// Self-checking bench for chimera_clu_clk_ctrl: vector tables plus hand-written sequences,
// with expected outputs queued at drive time and compared after the following clock edge.
module tb_chimera_clu_clk_ctrl;
  localparam int N = 5;

  logic         clk_i  = 1'b0;
  logic         rst_ni = 1'b0;
  logic [N-1:0] gate_req = '0, busy = '0, start = '0, stop = '0;
  logic [N-1:0] clk_en, isolate, gated, timeout, cnt_err;

  chimera_clu_clk_ctrl #(
    .NumClusters(N), .MaxOutstanding(16), .WakeCycles(4), .DrainTimeout(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .gate_req_i (gate_req),
    .clu_busy_i (busy),
    .txn_start_i(start),
    .txn_end_i  (stop),
    .clk_en_o   (clk_en),
    .isolate_o  (isolate),
    .gated_o    (gated),
    .timeout_o  (timeout),
    .cnt_err_o  (cnt_err)
  );

  always #5 clk_i = ~clk_i;

  // st holds one state letter per cluster, cluster 0 first: A/I/D/G/W.
  typedef struct {
    bit           rst_before;
    logic [N-1:0] gate, busy, start, stop;
    string        st;
    logic [N-1:0] tmo, err;
    string        name;
  } vec_t;

  typedef struct {
    string        name;
    logic [N-1:0] en, iso, gtd, tmo, err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic void decode(input string st, output logic [N-1:0] en, iso, gtd);
    en = '0; iso = '0; gtd = '0;
    for (int i = 0; i < N; i++) begin
      case (st[i])
        "A":          en[i] = 1'b1;
        "G":          begin iso[i] = 1'b1; gtd[i] = 1'b1; end
        "I", "D", "W": begin en[i] = 1'b1; iso[i] = 1'b1; end
        default:      en[i] = 1'bx;
      endcase
    end
  endfunction

  task automatic check_reset(input string name);
    check({name, ".en"},  clk_en,  '1);
    check({name, ".iso"}, isolate, '0);
    check({name, ".gtd"}, gated,   '0);
    check({name, ".tmo"}, timeout, '0);
    check({name, ".err"}, cnt_err, '0);
  endtask

  task automatic do_reset(input string name);
    rst_ni = 1'b0;
    gate_req = '0; busy = '0; start = '0; stop = '0;
    #2;
    check_reset(name);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic step(input logic [N-1:0] g, b, s, e, input string st,
                      input logic [N-1:0] tmo, err, input string name);
    exp_t x;
    gate_req = g; busy = b; start = s; stop = e;
    x.name = name;
    decode(st, x.en, x.iso, x.gtd);
    x.tmo = tmo;
    x.err = err;
    sb.push_back(x);
    @(posedge clk_i);
    #1;
    x = sb.pop_front();
    check({x.name, ".en"},  clk_en,  x.en);
    check({x.name, ".iso"}, isolate, x.iso);
    check({x.name, ".gtd"}, gated,   x.gtd);
    check({x.name, ".tmo"}, timeout, x.tmo);
    check({x.name, ".err"}, cnt_err, x.err);
  endtask

  task automatic add(input bit r, input logic [N-1:0] g, b, s, e, input string st,
                     input string name);
    vec_t v;
    v.rst_before = r; v.gate = g; v.busy = b; v.start = s; v.stop = e;
    v.st = st; v.tmo = '0; v.err = '0; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    string st;

    // Idle gate/ungate on cluster 0: gated after edge 2, wake at edge 10, active after edge 14.
    for (int k = 0; k < 16; k++) begin
      st = (k == 0) ? "IAAAA" : (k == 1) ? "DAAAA" : (k < 10) ? "GAAAA" :
           (k < 14) ? "WAAAA" : "AAAAA";
      add(k == 0, (k < 10) ? 5'b00001 : 5'b00000, '0, '0, '0, st,
          $sformatf("gate_ungate[%0d]", k));
    end

    // Drain with traffic on cluster 0; idle beats the expiring drain timer at edge 9.
    add(1, '0, '0, 5'b00001, '0, "AAAAA", "traffic.s0");
    add(0, '0, '0, 5'b00001, '0, "AAAAA", "traffic.s1");
    add(0, '0, '0, 5'b00001, '0, "AAAAA", "traffic.s2");
    for (int k = 0; k < 11; k++) begin
      add(0, 5'b00001, '0, (k == 7) ? 5'b00001 : 5'b00000,
          (k == 5 || k == 6 || k == 7 || k == 8) ? 5'b00001 : 5'b00000,
          (k == 0) ? "IAAAA" : (k < 9) ? "DAAAA" : "GAAAA",
          $sformatf("traffic[%0d]", k));
    end
    add(0, '0, '0, '0, '0, "WAAAA", "traffic.release");

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset($sformatf("reset@%0d", i));
      step(vecs[i].gate, vecs[i].busy, vecs[i].start, vecs[i].stop, vecs[i].st,
           vecs[i].tmo, vecs[i].err, vecs[i].name);
    end

    // Timeout on cluster 2 with busy held, no retry, clear and restart, then abort.
    do_reset("reset.timeout");
    step(5'b00100, 5'b00100, '0, '0, "AAIAA", '0, '0, "tmo.iso");
    for (int k = 1; k < 9; k++)
      step(5'b00100, 5'b00100, '0, '0, "AADAA", '0, '0, $sformatf("tmo.drain[%0d]", k));
    step(5'b00100, 5'b00100, '0, '0, "AAAAA", 5'b00100, '0, "tmo.expire");
    for (int k = 0; k < 3; k++)
      step(5'b00100, 5'b00100, '0, '0, "AAAAA", 5'b00100, '0, $sformatf("tmo.noretry[%0d]", k));
    step(5'b00000, 5'b00100, '0, '0, "AAAAA", '0, '0, "tmo.clear");
    step(5'b00100, 5'b00100, '0, '0, "AAIAA", '0, '0, "tmo.rearm");
    step(5'b00100, 5'b00100, '0, '0, "AADAA", '0, '0, "tmo.redrain");
    step(5'b00000, 5'b00100, '0, '0, "AAAAA", '0, '0, "abort");
    step(5'b00000, 5'b00100, '0, '0, "AAAAA", '0, '0, "abort.hold");

    // Overflow on cluster 4: saturates at 16, so 16 ends bring it back to idle.
    do_reset("reset.ovf");
    for (int k = 0; k < 16; k++)
      step('0, '0, 5'b10000, '0, "AAAAA", '0, '0, $sformatf("ovf.start[%0d]", k));
    step('0, '0, 5'b10000, '0, "AAAAA", '0, 5'b10000, "ovf.start16");
    for (int k = 0; k < 16; k++)
      step('0, '0, '0, 5'b10000, "AAAAA", '0, 5'b10000, $sformatf("ovf.end[%0d]", k));
    step(5'b10000, '0, '0, '0, "AAAAI", '0, 5'b10000, "ovf.iso");
    step(5'b10000, '0, '0, '0, "AAAAD", '0, 5'b10000, "ovf.drain");
    step(5'b10000, '0, '0, '0, "AAAAG", '0, 5'b10000, "ovf.gated");

    // Underflow on cluster 3: flag is sticky and the count holds at 0.
    do_reset("reset.udf");
    step('0, '0, '0, 5'b01000, "AAAAA", '0, 5'b01000, "udf.end");
    step('0, '0, '0, '0, "AAAAA", '0, 5'b01000, "udf.sticky");
    step(5'b01000, '0, '0, '0, "AAAIA", '0, 5'b01000, "udf.iso");
    step(5'b01000, '0, '0, '0, "AAADA", '0, 5'b01000, "udf.drain");
    step(5'b01000, '0, '0, '0, "AAAGA", '0, 5'b01000, "udf.gated");

    // Independence: clusters 0 and 3 gate together, 1 stays active; async reset mid-drain.
    do_reset("reset.indep");
    step('0, '0, '0, 5'b00010, "AAAAA", '0, 5'b00010, "indep.err1");
    step(5'b01001, 5'b01000, '0, '0, "IAAIA", '0, 5'b00010, "indep.iso");
    step(5'b01001, 5'b01000, '0, '0, "DAADA", '0, 5'b00010, "indep.drain");
    step(5'b01001, 5'b01000, '0, '0, "GAADA", '0, 5'b00010, "indep.split");
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset("async_reset");
    gate_req = '0; busy = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step('0, '0, '0, '0, "AAAAA", '0, '0, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chimera_clu_clk_ctrl.md
# chimera_clu_clk_ctrl

Per-cluster clock-gating sequencer for the cluster domain. It replaces direct register-to-gate wiring with a safe handshake: isolate, drain outstanding narrow AXI traffic and wait for cluster idle, then gate, and perform a timed wake on release. It sits between the top-level control registers and the per-cluster `tc_clk_gating` cells. It is parametrised in cluster count, outstanding depth, wake delay and drain timeout.

## Interface
Parameters:
- `NumClusters`, default 5: number of independently controlled clusters.
- `MaxOutstanding`, default 16: outstanding-transaction capacity per cluster. Counter width is `$clog2(MaxOutstanding+1)`.
- `WakeCycles`, default 4: cycles spent in WAKE. Must be ≥1; enforced by an elaboration assertion.
- `DrainTimeout`, default 1024: maximum cycles spent in DRAIN. A value of 0 disables the timeout.

Ports (all vectors `[NumClusters-1:0]`, bit i belongs to cluster i):
- `clk_i`  in  1  SoC clock. Single clock domain.
- `rst_ni`  in  1  asynchronous active-low reset.
- `gate_req_i`  in  N  level request from the register file; 1 = gate cluster.
- `clu_busy_i`  in  N  cluster reports internal activity.
- `txn_start_i`  in  N  one-cycle pulse per accepted AW or AR handshake into the cluster.
- `txn_end_i`  in  N  one-cycle pulse per completed B, or R with last, out of the cluster.
- `clk_en_o`  out  N  enable to the clock gate. Reset value 1.
- `isolate_o`  out  N  1 = integrator must stall new requests into the cluster. Reset value 0.
- `gated_o`  out  N  status: cluster clock is off. Reset value 0.
- `timeout_o`  out  N  sticky drain-timeout flag. Reset value 0.
- `cnt_err_o`  out  N  sticky counter overflow/underflow flag. Reset value 0.

## Operation
- There are N identical, independent FSMs with states ACTIVE, ISOLATE, DRAIN, GATED, WAKE. Reset state is ACTIVE.
- All outputs are Moore outputs decoded from registered state:
  - ACTIVE: en=1, iso=0
  - ISOLATE: en=1, iso=1
  - DRAIN: en=1, iso=1
  - GATED: en=0, iso=1, gated=1
  - WAKE: en=1, iso=1
- ACTIVE → ISOLATE when `gate_req_i`=1 and the rearm flag is set. The rearm flag is set at reset and whenever `gate_req_i`=0.
- ISOLATE → DRAIN unconditionally after 1 cycle. This absorbs a handshake that was accepted in the same cycle as isolation.
- DRAIN has the following exits:
  - If `gate_req_i`=0: → ACTIVE. This is an abort and has the highest priority.
  - Else if outstanding==0 and `clu_busy_i`=0: → GATED.
  - Else if `DrainTimeout`≠0 and the drain counter == `DrainTimeout-1`: → ACTIVE, set `timeout_o`, clear rearm.
- The drain counter resets to 0 on DRAIN entry and increments every DRAIN cycle.
- GATED → WAKE when `gate_req_i`=0.
- WAKE lasts exactly `WakeCycles` cycles, then → ACTIVE. `gate_req_i` is ignored during WAKE and re-evaluated in ACTIVE.
- `timeout_o` clears in any cycle where `gate_req_i`=0.
- Outstanding counter:
  - It counts in every state.
  - Start and end in the same cycle leave it unchanged.
  - Start at `MaxOutstanding` saturates the counter and sets `cnt_err_o`.
  - End at 0 holds the counter at 0 and sets `cnt_err_o`.
  - `cnt_err_o` clears only on reset.
- Pulses arriving while the cluster is GATED are protocol errors and are counted as above; no further handling.
- Reset mid-operation: every FSM returns to ACTIVE, counters go to 0, and all outputs take their reset values asynchronously.

## Timing
- `gate_req_i` rises before edge 0 with the cluster idle:
  - `isolate_o`=1 after edge 0 (ISOLATE).
  - DRAIN after edge 1.
  - `clk_en_o`=0 and `gated_o`=1 after edge 2.
  - Minimum gating latency is 3 cycles.
- `gate_req_i` falls while GATED, before edge k:
  - `clk_en_o`=1 after edge k.
  - `isolate_o`=0 after edge k+`WakeCycles`.
- Idle is sampled combinationally in DRAIN, using the current counter value and the current `clu_busy_i`.
- Idle has priority over timeout in the same cycle.

## Test plan
- Idle gate/ungate: `WakeCycles`=4.
  - Request rises at cycle 0 → `clk_en_o`=0 at cycle 3.
  - Release at cycle 10 → `clk_en_o`=1 at cycle 11, `isolate_o`=0 at cycle 15.
- Drain with traffic: 3 starts before the request, ends at cycles 5, 6 and 8.
  - GATED is entered only after edge 8.
  - A start and an end in the same cycle leave the count unchanged.
- Timeout: `DrainTimeout`=8, `clu_busy_i` held at 1.
  - ACTIVE with `timeout_o`=1 after 8 DRAIN cycles.
  - The held request does not retry.
  - Dropping the request for 1 cycle clears `timeout_o`; reasserting it restarts the sequence.
- Abort: request drops in DRAIN → ACTIVE next cycle, `isolate_o`=0, `gated_o` never asserted.
- Counter errors:
  - 17 starts with `MaxOutstanding`=16 → count stays 16 and `cnt_err_o`=1.
  - An end at count 0 → `cnt_err_o`=1.
- Independence and reset: gate clusters 0 and 3 concurrently while 1 stays ACTIVE, then assert `rst_ni`=0 mid-DRAIN → all outputs return to reset values immediately.
